// File: rtl/root_result_buffer.sv
// Capture stage for quadratic-solver results: either a hold-last register (MODE=0)
// or a DEPTH-entry FIFO with valid/ready handshake and sticky overflow (MODE=1).
module root_result_buffer #(
    parameter int WIDTH     = 4,
    parameter int NUM_ROOTS = 2,
    parameter int DEPTH     = 4,
    parameter int MODE      = 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_ROOTS*WIDTH-1:0] in_roots,
    input  logic [1:0]                 in_nroots,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_ROOTS*WIDTH-1:0] out_roots,
    output logic [1:0]                 out_nroots,
    output logic [LW-1:0]              level,
    output logic                       overflow,
    input  logic                       clr_ovf
);
    localparam int RW = NUM_ROOTS * WIDTH;
    localparam int EW = RW + 2;
    localparam int PW = $clog2(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its data stable while valid=1 and ready=0.
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;

    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] head;
    logic [EW-1:0] out_entry;

    assign fifo_full  = (level_q == LW'(DEPTH));
    assign fifo_empty = (level_q == '0);
    assign in_ready   = !rst && ((MODE == 0) || !fifo_full);
    assign out_valid  = (MODE == 0) ? hold_vld_q : !fifo_empty;
    assign accept     = in_valid && in_ready;
    assign pop        = (MODE != 0) && out_valid && out_ready;

    // Empty FIFO shows zeros so the head never exposes discarded entries.
    assign head      = mem_q[rd_ptr_q];
    assign out_entry = (MODE == 0) ? hold_q : (fifo_empty ? '0 : head);

    assign out_roots  = out_entry[RW-1:0];
    assign out_nroots = out_entry[EW-1 -: 2];
    assign level      = (MODE == 0) ? LW'(hold_vld_q) : level_q;
    assign overflow   = ovf_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;

        if (MODE == 0) begin
            if (accept) begin
                hold_d     = {in_nroots, in_roots};
                hold_vld_d = 1'b1;
            end
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(accept) - LW'(pop);
            // Set has priority over clear when both happen on one edge.
            if (clr_ovf)               ovf_d = 1'b0;
            if (in_valid && !in_ready) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end

    // Storage needs no reset: reads are gated by level.
    always_ff @(posedge clk) begin
        if ((MODE != 0) && accept) mem_q[wr_ptr_q] <= {in_nroots, in_roots};
    end

endmodule

// File: tb/tb_root_result_buffer.sv
// Bench for root_result_buffer: one FIFO instance (MODE=1) checked by an expected-queue
// scoreboard, plus one hold-register instance (MODE=0) checked directly.
module tb_root_result_buffer;
    localparam int WIDTH = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int EW    = NR * WIDTH + 2;

    logic clk = 1'b0;
    logic rst;

    logic             f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [NR*WIDTH-1:0] f_in_roots, f_out_roots;
    logic [1:0]       f_in_nroots, f_out_nroots;
    logic [LW-1:0]    f_level;
    logic             f_overflow, f_clr_ovf;

    logic             h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [NR*WIDTH-1:0] h_in_roots, h_out_roots;
    logic [1:0]       h_in_nroots, h_out_nroots;
    logic [LW-1:0]    h_level;
    logic             h_overflow, h_clr_ovf;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    int checks = 0;
    int errors = 0;

    root_result_buffer #(.WIDTH(WIDTH), .NUM_ROOTS(NR), .DEPTH(DEPTH), .MODE(1)) u_fifo (
        .clk(clk), .rst(rst),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_roots(f_in_roots), .in_nroots(f_in_nroots),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_roots(f_out_roots), .out_nroots(f_out_nroots),
        .level(f_level), .overflow(f_overflow), .clr_ovf(f_clr_ovf)
    );

    root_result_buffer #(.WIDTH(WIDTH), .NUM_ROOTS(NR), .DEPTH(DEPTH), .MODE(0)) u_hold (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_roots(h_in_roots), .in_nroots(h_in_nroots),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_roots(h_out_roots), .out_nroots(h_out_nroots),
        .level(h_level), .overflow(h_overflow), .clr_ovf(h_clr_ovf)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [EW-1:0] enc(input logic [1:0] nr, input logic [3:0] r1,
                                          input logic [3:0] r0);
        return {nr, r1, r0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one result to the FIFO; queue it as expected only if the bench expects acceptance.
    task automatic f_offer(input logic [EW-1:0] d, input bit expect_accept);
        f_in_valid  = 1'b1;
        f_in_roots  = d[NR*WIDTH-1:0];
        f_in_nroots = d[EW-1 -: 2];
        if (expect_accept) exp_q.push_back(d);
    endtask

    task automatic h_offer(input logic [EW-1:0] d);
        h_in_valid  = 1'b1;
        h_in_roots  = d[NR*WIDTH-1:0];
        h_in_nroots = d[EW-1 -: 2];
    endtask

    // ---------------- scoreboard monitor ----------------
    // Sampled at the falling edge: a pop takes effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst && f_out_valid && f_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_pop: got unexpected %0h expected nothing",
                         {f_out_nroots, f_out_roots});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({f_out_nroots, f_out_roots} !== mon_exp) begin
                    errors++;
                    $display("FAIL fifo_pop: got %0h expected %0h",
                             {f_out_nroots, f_out_roots}, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        f_in_valid = 1'b1; f_in_roots = 8'h5A; f_in_nroots = 2'd2;
        f_out_ready = 1'b0; f_clr_ovf = 1'b0;
        h_in_valid = 1'b1; h_in_roots = 8'hA5; h_in_nroots = 2'd1;
        h_out_ready = 1'b0; h_clr_ovf = 1'b0;

        // Reset with in_valid asserted: nothing accepted.
        #1;
        chk("rst_in_ready", 32'(f_in_ready), 32'd0);
        step();
        step();
        chk("rst_out_valid", 32'(f_out_valid), 32'd0);
        chk("rst_level", 32'(f_level), 32'd0);
        chk("rst_overflow", 32'(f_overflow), 32'd0);
        chk("rst_out_roots", 32'(f_out_roots), 32'd0);
        chk("rst_out_nroots", 32'(f_out_nroots), 32'd0);
        chk("rst_h_out_valid", 32'(h_out_valid), 32'd0);
        chk("rst_h_out_roots", 32'(h_out_roots), 32'd0);
        rst = 1'b0; f_in_valid = 1'b0; h_in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(f_in_ready), 32'd1);
        chk("post_rst_h_in_ready", 32'(h_in_ready), 32'd1);

        // Hold mode: (-3, 2) then (1, 1).
        h_offer(enc(2'd2, 4'd2, 4'hD));
        step();
        chk("hold_first", 32'({h_out_nroots, h_out_roots}), 32'(enc(2'd2, 4'd2, 4'hD)));
        chk("hold_valid1", 32'(h_out_valid), 32'd1);
        chk("hold_level1", 32'(h_level), 32'd1);
        h_offer(enc(2'd1, 4'd1, 4'd1));
        step();
        chk("hold_second", 32'({h_out_nroots, h_out_roots}), 32'(enc(2'd1, 4'd1, 4'd1)));
        h_in_valid = 1'b0;
        h_out_ready = 1'b1;
        h_in_roots = 8'hFF; h_in_nroots = 2'd3;
        for (int i = 0; i < 3; i++) step();
        chk("hold_keep", 32'({h_out_nroots, h_out_roots}), 32'(enc(2'd1, 4'd1, 4'd1)));
        chk("hold_valid_keep", 32'(h_out_valid), 32'd1);
        chk("hold_overflow", 32'(h_overflow), 32'd0);

        // FIFO fill to full, overflow on fifth, then drain.
        f_out_ready = 1'b0;
        f_offer(enc(2'd2, 4'hD, 4'd2), 1'b1); step();
        f_offer(enc(2'd1, 4'd7, 4'h8), 1'b1); step();
        f_offer(enc(2'd0, 4'h0, 4'hF), 1'b1); step();
        f_offer(enc(2'd3, 4'h9, 4'h6), 1'b1); step();
        f_in_valid = 1'b0;
        chk("full_level", 32'(f_level), 32'd4);
        chk("full_in_ready", 32'(f_in_ready), 32'd0);
        chk("full_overflow_clear", 32'(f_overflow), 32'd0);
        f_offer(enc(2'd2, 4'h3, 4'h3), 1'b0); step();
        f_in_valid = 1'b0;
        chk("ovf_set", 32'(f_overflow), 32'd1);
        chk("ovf_level", 32'(f_level), 32'd4);
        f_clr_ovf = 1'b1; step(); f_clr_ovf = 1'b0;
        chk("ovf_clr", 32'(f_overflow), 32'd0);
        f_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_level", 32'(f_level), 32'd0);
        chk("drain_out_valid", 32'(f_out_valid), 32'd0);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        chk("pop_empty_level", 32'(f_level), 32'd0);

        // Accept while empty with out_ready=1: no pop on that edge.
        f_offer(enc(2'd1, 4'h4, 4'hC), 1'b1); step();
        f_in_valid = 1'b0;
        chk("empty_accept_level", 32'(f_level), 32'd1);
        chk("empty_accept_valid", 32'(f_out_valid), 32'd1);
        step();
        chk("empty_accept_drained", 32'(f_level), 32'd0);

        // Simultaneous push/pop at level 2 for 10 cycles.
        f_out_ready = 1'b0;
        f_offer(enc(2'd2, 4'h1, 4'hE), 1'b1); step();
        f_offer(enc(2'd2, 4'h2, 4'hD), 1'b1); step();
        f_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f_offer(enc(2'(i % 3), 4'(i + 3), 4'(12 - i)), 1'b1);
            step();
            chk("stream_level", 32'(f_level), 32'd2);
        end
        f_in_valid = 1'b0;
        step(); step();
        chk("stream_level_end", 32'(f_level), 32'd0);
        chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Overflow set and clear on the same edge: set wins.
        f_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_offer(enc(2'd1, 4'(i), 4'(i + 8)), 1'b1);
            step();
        end
        f_offer(enc(2'd0, 4'h7, 4'h7), 1'b0);
        f_clr_ovf = 1'b1;
        step();
        f_in_valid = 1'b0;
        chk("ovf_set_wins", 32'(f_overflow), 32'd1);
        step();
        f_clr_ovf = 1'b0;
        chk("ovf_clr_alone", 32'(f_overflow), 32'd0);

        // Reset at level 3: stale entries must never reappear.
        f_out_ready = 1'b1; step(); f_out_ready = 1'b0;
        chk("pre_rst_level", 32'(f_level), 32'd3);
        rst = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("mid_rst_level", 32'(f_level), 32'd0);
        chk("mid_rst_out_valid", 32'(f_out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(f_in_ready), 32'd1);
        f_offer(enc(2'd2, 4'hB, 4'h5), 1'b1); step();
        f_in_valid = 1'b0;
        chk("post_rst_level1", 32'(f_level), 32'd1);
        f_out_ready = 1'b1; step(); f_out_ready = 1'b0;
        chk("post_rst_level0", 32'(f_level), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
